// File: rtl/beverage_vend_ctrl.sv
// Beverage vending sequencer: collects coins, runs the dispense handshake, returns change
// one 50-cent coin per cycle, and refunds after a dispenser timeout.
module beverage_vend_ctrl #(
    parameter int unsigned PRICE        = 3,
    parameter int unsigned CREDIT_W     = 3,
    parameter int unsigned DISP_TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [1:0]          coin,
    input  logic                cancel,
    input  logic                vend_ack,
    output logic                vend_req,
    output logic                change_pulse,
    output logic                coin_reject,
    output logic [CREDIT_W-1:0] credit,
    output logic                busy,
    output logic                fault
);

    localparam int unsigned MAX_CREDIT = (1 << CREDIT_W) - 1;
    localparam int unsigned TMO_W      = $clog2(DISP_TIMEOUT + 1);

    localparam logic [CREDIT_W:0]   MAX_WIDE   = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [CREDIT_W:0]   PRICE_WIDE = (CREDIT_W + 1)'(PRICE);
    localparam logic [CREDIT_W-1:0] PRICE_C    = CREDIT_W'(PRICE);
    localparam logic [TMO_W-1:0]    TMO_LAST   = TMO_W'(DISP_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

    state_t            state;
    logic [TMO_W-1:0]  tmo_cnt;
    logic [CREDIT_W:0] coin_val;
    logic [CREDIT_W:0] credit_sum;
    logic              coin_valid;
    logic              coin_accept;
    logic              price_hit;

    // NOTE: every signal gets a default before the case so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        coin_val   = '0;
        coin_valid = 1'b0;
        case (coin)
            2'b01: begin
                coin_val   = (CREDIT_W + 1)'(1);
                coin_valid = 1'b1;
            end
            2'b10: begin
                coin_val   = (CREDIT_W + 1)'(2);
                coin_valid = 1'b1;
            end
            default: ;
        endcase
    end

    // One extra bit on the sum lets an overflowing coin be detected and refused.
    assign credit_sum  = {1'b0, credit} + coin_val;
    assign coin_accept = ((state == IDLE) || (state == COLLECT)) && coin_valid && !cancel
                         && (credit_sum <= MAX_WIDE);
    assign price_hit   = (credit_sum >= PRICE_WIDE);

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            credit       <= '0;
            tmo_cnt      <= '0;
            vend_req     <= 1'b0;
            change_pulse <= 1'b0;
            coin_reject  <= 1'b0;
            busy         <= 1'b0;
            fault        <= 1'b0;
        end else begin
            coin_reject <= (coin != 2'b00) && !coin_accept;

            case (state)
                IDLE, COLLECT: begin
                    if ((state == COLLECT) && cancel) begin
                        state        <= CHANGE;
                        change_pulse <= 1'b1;
                        busy         <= 1'b1;
                    end else if (coin_accept) begin
                        credit <= credit_sum[CREDIT_W-1:0];
                        if (price_hit) begin
                            state    <= VEND;
                            vend_req <= 1'b1;
                            busy     <= 1'b1;
                            tmo_cnt  <= '0;
                        end else begin
                            state <= COLLECT;
                        end
                    end
                end

                VEND: begin
                    // An ack on the timeout cycle takes precedence, so no fault is raised.
                    if (vend_ack) begin
                        credit   <= credit - PRICE_C;
                        vend_req <= 1'b0;
                        if (credit != PRICE_C) begin
                            state        <= CHANGE;
                            change_pulse <= 1'b1;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        fault        <= 1'b1;
                        vend_req     <= 1'b0;
                        state        <= CHANGE;
                        change_pulse <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end

                CHANGE: begin
                    credit <= credit - CREDIT_W'(1);
                    if (credit == CREDIT_W'(1)) begin
                        state        <= IDLE;
                        change_pulse <= 1'b0;
                        busy         <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
